mat_row_store: RTL and testbench

//  Multi-matrix complex row store that replaces the behavioural row memories around lu,

---
 rtl/mat_row_store_pkg.sv | 16 +
 rtl/mat_row_store_rdport.sv | 40 ++++
 rtl/mat_row_store.sv | 164 ++++++++++++++++
 tb/tb_mat_row_store.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mat_row_store_pkg.sv
// Shared types and default geometry for the multi-matrix complex row store.
package mat_store_pkg;

  localparam int SIZE_DEF     = 4;
  localparam int WIDTH_DEF    = 64;
  localparam int NUM_MATS_DEF = 4;

  localparam int ELEM_W = 2 * WIDTH_DEF;    // {imag, real}
  localparam int ROW_W  = SIZE_DEF * ELEM_W;

  typedef logic [ELEM_W-1:0]           elem_t;
  typedef elem_t [SIZE_DEF-1:0]        row_t;

  typedef enum logic {IDLE, CLEAR} state_e;

endpackage

// File: rtl/mat_row_store_rdport.sv
// One registered read port: returns the addressed row and echoes its address
// one cycle after the request. Row/addr hold when no request is presented.
module mat_row_store_rdport #(
  parameter int RW = 512,
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [RW-1:0] row_i,
  input  logic [AW-1:0] addr_i,
  input  logic          valid_i,
  output logic [RW-1:0] row_o,
  output logic [AW-1:0] addr_o,
  output logic          valid_o
);

  logic          vld_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] addr_q;

  // Capture row and address on a request; valid tracks the request 1 cycle late.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q <= valid_i;
      if (valid_i) begin
        row_q  <= row_i;
        addr_q <= addr_i;
      end
    end
  end

  assign row_o   = row_q;
  assign addr_o  = addr_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/mat_row_store.sv
// NUM_MATS resident SIZExSIZE complex matrices with two read ports, row and
// transposed-column writes, a per-matrix sequenced clear and write-coverage
// tracking (mat_done_o).
module mat_row_store
  import mat_store_pkg::*;
#(
  parameter int SIZE     = SIZE_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NUM_MATS = NUM_MATS_DEF,
  parameter int AW       = $clog2(SIZE),
  parameter int MW       = $clog2(NUM_MATS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [MW-1:0]           rd0_mat_i,
  input  logic [AW-1:0]           rd0_addr_i,
  input  logic                    rd0_valid_i,
  output logic [SIZE*2*WIDTH-1:0] rd0_row_o,
  output logic [AW-1:0]           rd0_addr_o,
  output logic                    rd0_valid_o,
  input  logic [MW-1:0]           rd1_mat_i,
  input  logic [AW-1:0]           rd1_addr_i,
  input  logic                    rd1_valid_i,
  output logic [SIZE*2*WIDTH-1:0] rd1_row_o,
  output logic [AW-1:0]           rd1_addr_o,
  output logic                    rd1_valid_o,
  input  logic [MW-1:0]           wr_mat_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [SIZE*2*WIDTH-1:0] wr_row_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [MW-1:0]           cw_mat_i,
  input  logic [AW-1:0]           cw_addr_i,
  input  logic [SIZE*2*WIDTH-1:0] cw_col_i,
  input  logic                    cw_valid_i,
  input  logic [MW-1:0]           clr_mat_i,
  input  logic                    clr_valid_i,
  output logic                    clr_ready_o,
  output logic                    busy_o,
  output logic [NUM_MATS-1:0]     mat_done_o
);

  localparam int EW   = 2 * WIDTH;
  localparam int RWID = SIZE * EW;
  localparam int NRP  = 2;

  // Storage is deliberately not reset.
  logic [SIZE-1:0][EW-1:0] mem [NUM_MATS][SIZE];

  state_e                        state;
  logic [MW-1:0]                 clr_mat_q;
  logic [AW-1:0]                 clr_cnt;
  logic                          busy_q, clr_rdy_q;
  logic [NUM_MATS-1:0][SIZE-1:0] bitmap_q, bitmap_d;
  logic [NUM_MATS-1:0]           done_q, done_d;

  logic clearing, hit_wr, hit_cw, wr_fire, cw_fire, clr_acc;

  assign clearing = (state == CLEAR);
  assign hit_wr   = clearing && (wr_mat_i == clr_mat_q);
  assign hit_cw   = clearing && (cw_mat_i == clr_mat_q);
  assign wr_fire  = wr_valid_i && !hit_wr;
  assign cw_fire  = cw_valid_i && !hit_cw;
  assign clr_acc  = (state == IDLE) && clr_valid_i;

  assign wr_ready_o  = !hit_wr;
  assign busy_o      = busy_q;
  assign clr_ready_o = clr_rdy_q;
  assign mat_done_o  = done_q;

  // Array writes: row, then column (so the column wins the shared element), then clear.
  always_ff @(posedge clk_i) begin
    if (wr_fire)
      mem[wr_mat_i][wr_addr_i] <= wr_row_i;
    if (cw_fire)
      for (int k = 0; k < SIZE; k++)
        mem[cw_mat_i][k][cw_addr_i] <= cw_col_i[k*EW +: EW];
    if (clearing && !rst_i)
      mem[clr_mat_q][clr_cnt] <= '0;
  end

  // Next write-coverage bitmap; a clear acceptance zeroes its matrix last so it wins.
  always_comb begin
    bitmap_d = bitmap_q;
    if (wr_fire) bitmap_d[wr_mat_i][wr_addr_i] = 1'b1;
    if (cw_fire) bitmap_d[cw_mat_i][cw_addr_i] = 1'b1;
    if (clr_acc) bitmap_d[clr_mat_i] = '0;
    for (int m = 0; m < NUM_MATS; m++)
      done_d[m] = &bitmap_d[m];
  end

  // Bitmap and done flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitmap_q <= '0;
      done_q   <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      done_q   <= done_d;
    end
  end

  // Clear sequencer: one row per cycle, SIZE cycles total.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      clr_mat_q <= '0;
      clr_cnt   <= '0;
      busy_q    <= 1'b0;
      clr_rdy_q <= 1'b1;
    end else begin
      case (state)
        IDLE: if (clr_valid_i) begin
          state     <= CLEAR;
          clr_mat_q <= clr_mat_i;
          clr_cnt   <= '0;
          busy_q    <= 1'b1;
          clr_rdy_q <= 1'b0;
        end
        CLEAR: begin
          if (clr_cnt == AW'(SIZE-1)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            clr_rdy_q <= 1'b1;
          end
          clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read ports
  logic [NRP-1:0][MW-1:0]   rd_mat;
  logic [NRP-1:0][AW-1:0]   rd_addr, rd_addr_q;
  logic [NRP-1:0]           rd_vld, rd_vld_q;
  logic [NRP-1:0][RWID-1:0] rd_sel, rd_row_q;

  assign rd_mat  = {rd1_mat_i, rd0_mat_i};
  assign rd_addr = {rd1_addr_i, rd0_addr_i};
  assign rd_vld  = {rd1_valid_i, rd0_valid_i};

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    assign rd_sel[p] = mem[rd_mat[p]][rd_addr[p]];
    mat_row_store_rdport #(.RW(RWID), .AW(AW)) u_rd (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .row_i   (rd_sel[p]),
      .addr_i  (rd_addr[p]),
      .valid_i (rd_vld[p]),
      .row_o   (rd_row_q[p]),
      .addr_o  (rd_addr_q[p]),
      .valid_o (rd_vld_q[p])
    );
  end

  assign rd0_row_o   = rd_row_q[0];
  assign rd0_addr_o  = rd_addr_q[0];
  assign rd0_valid_o = rd_vld_q[0];
  assign rd1_row_o   = rd_row_q[1];
  assign rd1_addr_o  = rd_addr_q[1];
  assign rd1_valid_o = rd_vld_q[1];

endmodule

// File: tb/tb_mat_row_store.sv
// Directed bench for mat_row_store with the default 4x4, 64-bit, 4-matrix geometry.
module tb_mat_row_store;
  import mat_store_pkg::*;

  logic          clk_i = 0, rst_i = 1;
  logic [1:0]    rd0_mat_i, rd0_addr_i, rd0_addr_o, rd1_mat_i, rd1_addr_i, rd1_addr_o;
  logic          rd0_valid_i, rd0_valid_o, rd1_valid_i, rd1_valid_o;
  logic [511:0]  rd0_row_o, rd1_row_o, wr_row_i, cw_col_i;
  logic [1:0]    wr_mat_i, wr_addr_i, cw_mat_i, cw_addr_i, clr_mat_i;
  logic          wr_valid_i, wr_ready_o, cw_valid_i, clr_valid_i, clr_ready_o, busy_o;
  logic [3:0]    mat_done_o;

  int total = 0, bad = 0;

  mat_row_store dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd0_mat_i(rd0_mat_i), .rd0_addr_i(rd0_addr_i), .rd0_valid_i(rd0_valid_i),
    .rd0_row_o(rd0_row_o), .rd0_addr_o(rd0_addr_o), .rd0_valid_o(rd0_valid_o),
    .rd1_mat_i(rd1_mat_i), .rd1_addr_i(rd1_addr_i), .rd1_valid_i(rd1_valid_i),
    .rd1_row_o(rd1_row_o), .rd1_addr_o(rd1_addr_o), .rd1_valid_o(rd1_valid_o),
    .wr_mat_i(wr_mat_i), .wr_addr_i(wr_addr_i), .wr_row_i(wr_row_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .cw_mat_i(cw_mat_i), .cw_addr_i(cw_addr_i), .cw_col_i(cw_col_i), .cw_valid_i(cw_valid_i),
    .clr_mat_i(clr_mat_i), .clr_valid_i(clr_valid_i), .clr_ready_o(clr_ready_o),
    .busy_o(busy_o), .mat_done_o(mat_done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic elem_t el(real re, real im);
    return {$realtobits(im), $realtobits(re)};
  endfunction

  function automatic row_t rowf(real base);
    row_t r;
    for (int j = 0; j < 4; j++) r[j] = el(base + j, 0.0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input int m, input int a, input row_t r);
    wr_mat_i = 2'(m); wr_addr_i = 2'(a); wr_row_i = r; wr_valid_i = 1;
    tick();
    wr_valid_i = 0;
  endtask

  task automatic rd(input int p, input int m, input int a, output row_t r,
                    output logic v, output logic [1:0] ao);
    if (p == 0) begin rd0_mat_i = 2'(m); rd0_addr_i = 2'(a); rd0_valid_i = 1; end
    else        begin rd1_mat_i = 2'(m); rd1_addr_i = 2'(a); rd1_valid_i = 1; end
    tick();
    rd0_valid_i = 0; rd1_valid_i = 0;
    r  = (p == 0) ? rd0_row_o : rd1_row_o;
    v  = (p == 0) ? rd0_valid_o : rd1_valid_o;
    ao = (p == 0) ? rd0_addr_o : rd1_addr_o;
  endtask

  task automatic test_reset();
    rst_i = 1; tick(); tick(); rst_i = 0;
    total++; if (rd0_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rd0_valid got=%b exp=0", rd0_valid_o); end
    total++; if (rd1_row_o !== '0) begin bad++; $display("FAIL reset_rd1_row got=%h exp=0", rd1_row_o); end
    total++; if (rd0_addr_o !== 2'd0) begin bad++; $display("FAIL reset_rd0_addr got=%0d exp=0", rd0_addr_o); end
    total++; if ({wr_ready_o, clr_ready_o, busy_o} !== 3'b110) begin bad++; $display("FAIL reset_ctl got=%b exp=110", {wr_ready_o, clr_ready_o, busy_o}); end
    total++; if (mat_done_o !== 4'h0) begin bad++; $display("FAIL reset_done got=%b exp=0000", mat_done_o); end
  endtask

  task automatic test_row_write();
    row_t r, exp; logic v; logic [1:0] a;
    for (int j = 0; j < 4; j++) exp[j] = el(j, j + 0.5);
    wr(1, 2, exp);
    rd(0, 1, 2, r, v, a);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL rw_valid got=%b exp=1", v); end
    total++; if (a !== 2'd2) begin bad++; $display("FAIL rw_addr got=%0d exp=2", a); end
    total++; if (r !== exp) begin bad++; $display("FAIL rw_data got=%h exp=%h", r, exp); end
    tick();
    total++; if (rd0_valid_o !== 1'b0) begin bad++; $display("FAIL rw_valid_drop got=%b exp=0", rd0_valid_o); end
    total++; if (rd0_row_o !== exp) begin bad++; $display("FAIL rw_hold got=%h exp=%h", rd0_row_o, exp); end
  endtask

  task automatic test_col_write();
    row_t r, exp, col; logic v; logic [1:0] a;
    for (int k = 0; k < 4; k++) wr(0, k, rowf(10.0 * k));
    for (int k = 0; k < 4; k++) col[k] = el(k, 0.0);
    cw_mat_i = 0; cw_addr_i = 3; cw_col_i = col; cw_valid_i = 1;
    tick(); cw_valid_i = 0;
    for (int k = 0; k < 4; k++) begin
      exp = rowf(10.0 * k); exp[3] = el(k, 0.0);
      rd(1, 0, k, r, v, a);
      total++; if (r !== exp) begin bad++; $display("FAIL col_row%0d got=%h exp=%h", k, r, exp); end
    end
  endtask

  task automatic test_row_col_same();
    row_t r, exp, col; logic v; logic [1:0] a;
    for (int k = 0; k < 4; k++) begin exp[k] = el(5.0, 0.0); col[k] = el(9.0, 0.0); end
    wr_mat_i = 3; wr_addr_i = 1; wr_row_i = exp; wr_valid_i = 1;
    cw_mat_i = 3; cw_addr_i = 2; cw_col_i = col; cw_valid_i = 1;
    tick(); wr_valid_i = 0; cw_valid_i = 0;
    exp[2] = el(9.0, 0.0);
    rd(0, 3, 1, r, v, a);
    total++; if (r !== exp) begin bad++; $display("FAIL same_row1 got=%h exp=%h", r, exp); end
    rd(0, 3, 2, r, v, a);
    total++; if (r[2] !== el(9.0, 0.0)) begin bad++; $display("FAIL same_col_r2 got=%h exp=%h", r[2], el(9.0, 0.0)); end
    total++; if (mat_done_o[3] !== 1'b0) begin bad++; $display("FAIL same_done_early got=%b exp=0", mat_done_o[3]); end
    wr(3, 0, rowf(1.0));
    wr(3, 3, rowf(2.0));
    total++; if (mat_done_o[3] !== 1'b1) begin bad++; $display("FAIL same_done_bits got=%b exp=1", mat_done_o[3]); end
  endtask

  task automatic test_done_clear();
    row_t r; logic v; logic [1:0] a; int n;
    for (int k = 0; k < 3; k++) wr(2, k, rowf(100.0 + k));
    total++; if (mat_done_o[2] !== 1'b0) begin bad++; $display("FAIL done_3of4 got=%b exp=0", mat_done_o[2]); end
    wr(2, 3, rowf(103.0));
    total++; if (mat_done_o[2] !== 1'b1) begin bad++; $display("FAIL done_4of4 got=%b exp=1", mat_done_o[2]); end
    clr_mat_i = 2; clr_valid_i = 1; tick(); clr_valid_i = 0;
    total++; if (mat_done_o[2] !== 1'b0) begin bad++; $display("FAIL clr_done_fall got=%b exp=0", mat_done_o[2]); end
    total++; if ({busy_o, clr_ready_o} !== 2'b10) begin bad++; $display("FAIL clr_busy got=%b exp=10", {busy_o, clr_ready_o}); end
    n = 0;
    while (busy_o && n < 20) begin tick(); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL clr_len got=%0d exp=4", n); end
    for (int k = 0; k < 4; k++) begin
      rd(k % 2, 2, k, r, v, a);
      total++; if (r !== '0) begin bad++; $display("FAIL clr_row%0d got=%h exp=0", k, r); end
    end
  endtask

  task automatic test_clear_stall();
    row_t r, x, y; logic v; logic [1:0] a; int n;
    x = rowf(7.0); y = rowf(8.0);
    clr_mat_i = 2; clr_valid_i = 1; tick(); clr_valid_i = 0;
    wr_mat_i = 3; wr_addr_i = 0; wr_row_i = y; wr_valid_i = 1; #1;
    total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL stall_other_rdy got=%b exp=1", wr_ready_o); end
    tick();
    wr_mat_i = 2; wr_addr_i = 1; wr_row_i = x; #1;
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL stall_same_rdy got=%b exp=0", wr_ready_o); end
    n = 0;
    while (!wr_ready_o && n < 20) begin tick(); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL stall_len got=%0d exp=3", n); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", busy_o); end
    tick(); wr_valid_i = 0;
    rd(0, 2, 1, r, v, a);
    total++; if (r !== x) begin bad++; $display("FAIL stall_commit got=%h exp=%h", r, x); end
    rd(1, 3, 0, r, v, a);
    total++; if (r !== y) begin bad++; $display("FAIL stall_other got=%h exp=%h", r, y); end
    rd(0, 2, 2, r, v, a);
    total++; if (r !== '0) begin bad++; $display("FAIL stall_cleared got=%h exp=0", r); end
  endtask

  task automatic test_read_first();
    row_t r, oldr, newr; logic v; logic [1:0] a;
    oldr = rowf(20.0); newr = rowf(30.0);
    wr(1, 0, oldr);
    wr_mat_i = 1; wr_addr_i = 0; wr_row_i = newr; wr_valid_i = 1;
    rd(0, 1, 0, r, v, a);
    wr_valid_i = 0;
    total++; if (r !== oldr) begin bad++; $display("FAIL rf_old got=%h exp=%h", r, oldr); end
    rd(0, 1, 0, r, v, a);
    total++; if (r !== newr) begin bad++; $display("FAIL rf_new got=%h exp=%h", r, newr); end
  endtask

  task automatic test_reset_mid_clear();
    row_t r; logic v; logic [1:0] a;
    for (int k = 0; k < 4; k++) wr(0, k, rowf(40.0 + k));
    clr_mat_i = 0; clr_valid_i = 1; tick(); clr_valid_i = 0;
    tick();
    rst_i = 1; tick(); rst_i = 0;
    total++; if ({busy_o, clr_ready_o} !== 2'b01) begin bad++; $display("FAIL rst_mid got=%b exp=01", {busy_o, clr_ready_o}); end
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_stay got=%b exp=0", busy_o); end
    rd(0, 0, 0, r, v, a);
    total++; if (r !== '0) begin bad++; $display("FAIL rst_row0 got=%h exp=0", r); end
    rd(1, 0, 3, r, v, a);
    total++; if (r !== rowf(43.0)) begin bad++; $display("FAIL rst_row3 got=%h exp=%h", r, rowf(43.0)); end
  endtask

  initial begin
    rd0_mat_i = 0; rd0_addr_i = 0; rd0_valid_i = 0;
    rd1_mat_i = 0; rd1_addr_i = 0; rd1_valid_i = 0;
    wr_mat_i = 0; wr_addr_i = 0; wr_row_i = '0; wr_valid_i = 0;
    cw_mat_i = 0; cw_addr_i = 0; cw_col_i = '0; cw_valid_i = 0;
    clr_mat_i = 0; clr_valid_i = 0;
    test_reset();
    test_row_write();
    test_col_write();
    test_row_col_same();
    test_done_clear();
    test_clear_stall();
    test_read_first();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
